// File: rtl/mul_div_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mul_div_unit_pkg
// Purpose : Shared encodings for the iterative RV64M multiply/divide unit:
//           operation codes (RISC-V funct3 order) and FSM state encodings.
// Rev     : 1.0  initial release
// ============================================================================
package mul_div_unit_pkg;

    localparam int MDU_OP_W = 3;

    typedef enum logic [MDU_OP_W-1:0] {
        MDU_MUL    = 3'd0,
        MDU_MULH   = 3'd1,
        MDU_MULHSU = 3'd2,
        MDU_MULHU  = 3'd3,
        MDU_DIV    = 3'd4,
        MDU_DIVU   = 3'd5,
        MDU_REM    = 3'd6,
        MDU_REMU   = 3'd7
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } mdu_state_e;

endpackage
`default_nettype wire

// File: rtl/mdu_operand_prep.sv
`default_nettype none
// ============================================================================
// Module  : mdu_operand_prep
// Purpose : Combinational operand preparation for mul_div_unit. Applies the
//           *W-form extension, converts signed operands to magnitudes,
//           produces the result-negate flag and detects the divide-by-zero
//           and signed-overflow special cases together with their results.
// Ports   : i_mdu_op, i_is_word, i_operator_1, i_operator_2  -> request
//           o_mag_a / o_mag_b     operand magnitudes
//           o_neg_result          negate final product/quotient/remainder
//           o_special             special case, bypass the iteration
//           o_special_result      result to use when o_special is set
// Rev     : 1.0  initial release
// ============================================================================
module mdu_operand_prep
    import mul_div_unit_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [MDU_OP_W-1:0] i_mdu_op,
    input  logic                i_is_word,
    input  logic [XLEN-1:0]     i_operator_1,
    input  logic [XLEN-1:0]     i_operator_2,
    output logic [XLEN-1:0]     o_mag_a,
    output logic [XLEN-1:0]     o_mag_b,
    output logic                o_neg_result,
    output logic                o_special,
    output logic [XLEN-1:0]     o_special_result
);

    localparam int c_half = XLEN / 2;

    logic            w_a_signed;
    logic            w_b_signed;
    logic            w_is_div_op;
    logic            w_is_rem_op;
    logic [XLEN-1:0] w_ext_a;
    logic [XLEN-1:0] w_ext_b;
    logic            w_a_neg;
    logic            w_b_neg;
    logic            w_div_zero;
    logic            w_overflow;
    logic            w_a_most_neg;

    always_comb begin
        w_a_signed  = (i_mdu_op == MDU_MULH) || (i_mdu_op == MDU_MULHSU) ||
                      (i_mdu_op == MDU_DIV)  || (i_mdu_op == MDU_REM);
        w_b_signed  = (i_mdu_op == MDU_MULH) || (i_mdu_op == MDU_DIV) ||
                      (i_mdu_op == MDU_REM);
        w_is_div_op = i_mdu_op[2];
        w_is_rem_op = i_mdu_op[2] & i_mdu_op[1];

        if (i_is_word) begin
            w_ext_a = {{c_half{w_a_signed & i_operator_1[c_half-1]}}, i_operator_1[c_half-1:0]};
            w_ext_b = {{c_half{w_b_signed & i_operator_2[c_half-1]}}, i_operator_2[c_half-1:0]};
        end else begin
            w_ext_a = i_operator_1;
            w_ext_b = i_operator_2;
        end

        w_a_neg = w_a_signed & w_ext_a[XLEN-1];
        w_b_neg = w_b_signed & w_ext_b[XLEN-1];
        o_mag_a = w_a_neg ? -w_ext_a : w_ext_a;
        o_mag_b = w_b_neg ? -w_ext_b : w_ext_b;

        // Remainder follows the dividend's sign; everything else follows the sign product.
        o_neg_result = w_is_rem_op ? w_a_neg : (w_a_neg ^ w_b_neg);

        // The most-negative test looks at the narrow value for *W forms.
        if (i_is_word) begin
            w_a_most_neg = (w_ext_a[c_half-1:0] == {1'b1, {(c_half-1){1'b0}}});
        end else begin
            w_a_most_neg = (w_ext_a == {1'b1, {(XLEN-1){1'b0}}});
        end

        w_div_zero = w_is_div_op && (w_ext_b == '0);
        w_overflow = w_is_div_op && w_a_signed && w_a_most_neg && (w_ext_b == '1);
        o_special  = w_div_zero | w_overflow;

        if (w_div_zero) begin
            o_special_result = w_is_rem_op ? w_ext_a : '1;
        end else if (w_overflow) begin
            o_special_result = w_is_rem_op ? '0 : w_ext_a;
        end else begin
            o_special_result = '0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module  : mul_div_unit
// Purpose : Iterative RV64M multiply/divide unit. Radix-2 shift-add multiply
//           and restoring divide, one bit per cycle, with valid/ready
//           handshakes on the request and result sides.
// Ports   : clk, rst (sync, active high)
//           in_valid/in_ready, mdu_op, is_word, operator_1, operator_2
//           flush        abandon any in-flight operation
//           out_valid/out_ready, mdu_result (stable while out_valid)
// Rev     : 1.0  initial release
// ============================================================================
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int CNT_W = 7
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [MDU_OP_W-1:0] mdu_op,
    input  logic                is_word,
    input  logic [XLEN-1:0]     operator_1,
    input  logic [XLEN-1:0]     operator_2,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     mdu_result
);

    localparam int             c_half     = XLEN / 2;
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(XLEN - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    mdu_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [2*XLEN-1:0]     acc_q, acc_d;      // MUL: {high, low/multiplier}; DIV: {remainder, quotient}
    logic [XLEN-1:0]       b_q, b_d;          // multiplicand or divisor magnitude
    logic [MDU_OP_W-1:0]   op_q, op_d;
    logic                  is_word_q, is_word_d;
    logic                  neg_q, neg_d;
    logic                  special_q, special_d;
    logic                  in_ready_q, in_ready_d;
    logic                  out_valid_q, out_valid_d;
    logic [XLEN-1:0]       result_q, result_d;

    logic [XLEN-1:0]       w_mag_a, w_mag_b, w_special_result;
    logic                  w_neg_result, w_special;
    logic [XLEN:0]         w_mul_sum;
    logic [XLEN:0]         w_rem_shift;
    logic [XLEN:0]         w_rem_diff;
    logic                  w_q_bit;
    logic [XLEN-1:0]       w_rem_next;
    logic [2*XLEN-1:0]     w_prod;
    logic [XLEN-1:0]       w_raw;
    logic [XLEN-1:0]       w_final;

    mdu_operand_prep #(
        .XLEN (XLEN)
    ) u_operand_prep (
        .i_mdu_op         (mdu_op),
        .i_is_word        (is_word),
        .i_operator_1     (operator_1),
        .i_operator_2     (operator_2),
        .o_mag_a          (w_mag_a),
        .o_mag_b          (w_mag_b),
        .o_neg_result     (w_neg_result),
        .o_special        (w_special),
        .o_special_result (w_special_result)
    );

    // Shared datapath: one multiply step, one divide step, result formatting.
    always_comb begin
        w_mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
        // Partial remainder shifted left with the next dividend bit brought in.
        w_rem_shift = acc_q[2*XLEN-1:XLEN-1];
        w_rem_diff  = w_rem_shift - {1'b0, b_q};
        w_q_bit     = ~w_rem_diff[XLEN];
        w_rem_next  = w_q_bit ? w_rem_diff[XLEN-1:0] : w_rem_shift[XLEN-1:0];

        w_prod = neg_q ? -acc_q : acc_q;
        if (special_q) begin
            w_raw = acc_q[XLEN-1:0];
        end else begin
            case (op_q)
                MDU_MUL:                        w_raw = w_prod[XLEN-1:0];
                MDU_MULH, MDU_MULHSU, MDU_MULHU: w_raw = w_prod[2*XLEN-1:XLEN];
                MDU_DIV, MDU_DIVU:              w_raw = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
                default:                        w_raw = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
            endcase
        end
        w_final = is_word_q ? {{c_half{w_raw[c_half-1]}}, w_raw[c_half-1:0]} : w_raw;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        b_d         = b_q;
        op_d        = op_q;
        is_word_d   = is_word_q;
        neg_d       = neg_q;
        special_d   = special_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    op_d       = mdu_op;
                    is_word_d  = is_word;
                    b_d        = w_mag_b;
                    neg_d      = w_neg_result;
                    special_d  = w_special;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    if (w_special) begin
                        acc_d   = {{XLEN{1'b0}}, w_special_result};
                        state_d = ST_DONE;
                    end else begin
                        acc_d   = {{XLEN{1'b0}}, w_mag_a};
                        state_d = mdu_op[2] ? ST_DIV : ST_MUL;
                    end
                end
            end
            ST_MUL: begin
                acc_d = {w_mul_sum, acc_q[XLEN-1:1]};
                if (cnt_q == c_cnt_last) state_d = ST_DONE;
                else                     cnt_d   = cnt_q + c_cnt_one;
            end
            ST_DIV: begin
                acc_d = {w_rem_next, acc_q[XLEN-2:0], w_q_bit};
                if (cnt_q == c_cnt_last) state_d = ST_DONE;
                else                     cnt_d   = cnt_q + c_cnt_one;
            end
            ST_DONE: begin
                // First DONE cycle formats and registers the result; then wait for the consumer.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    result_d    = w_final;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (flush) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            b_q         <= '0;
            op_q        <= '0;
            is_word_q   <= 1'b0;
            neg_q       <= 1'b0;
            special_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            b_q         <= b_d;
            op_q        <= op_d;
            is_word_q   <= is_word_d;
            neg_q       <= neg_d;
            special_q   <= special_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign mdu_result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_mul_div_unit
// Purpose : Self-checking bench for mul_div_unit: directed cases, randomized
//           operations against a plain-arithmetic reference, backpressure,
//           flush and mid-operation reset.
// Rev     : 1.0  initial release
// ============================================================================
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

    localparam int XLEN = 64;
    localparam int LONG_LAT = XLEN + 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      mdu_op;
    logic            is_word;
    logic [XLEN-1:0] operator_1;
    logic [XLEN-1:0] operator_2;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] mdu_result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mul_div_unit #(
        .XLEN  (XLEN),
        .CNT_W (7)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mdu_op     (mdu_op),
        .is_word    (is_word),
        .operator_1 (operator_1),
        .operator_2 (operator_2),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .mdu_result (mdu_result)
    );

    task automatic check_result(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: RISC-V M-extension semantics from plain arithmetic.
    function automatic logic [63:0] ref_model(input logic [2:0] op, input logic w,
                                              input logic [63:0] a, input logic [63:0] b);
        logic [127:0]       pa, pb, p;
        logic signed [31:0] a32, b32, q32, m32;
        logic [31:0]        r32;
        longint             sa, sb, q64, m64;
        a32 = a[31:0];
        b32 = b[31:0];
        sa  = a;
        sb  = b;
        if (w) begin
            if (op == MDU_MUL) begin
                r32 = a[31:0] * b[31:0];
            end else if (b[31:0] == 32'd0) begin
                r32 = (op == MDU_DIV || op == MDU_DIVU) ? 32'hFFFF_FFFF : a[31:0];
            end else if ((op == MDU_DIV || op == MDU_REM) && a[31:0] == 32'h8000_0000 &&
                         b[31:0] == 32'hFFFF_FFFF) begin
                r32 = (op == MDU_DIV) ? a[31:0] : 32'd0;
            end else begin
                q32 = a32 / b32;
                m32 = a32 % b32;
                case (op)
                    MDU_DIV:  r32 = q32;
                    MDU_DIVU: r32 = a[31:0] / b[31:0];
                    MDU_REM:  r32 = m32;
                    default:  r32 = a[31:0] % b[31:0];
                endcase
            end
            return {{32{r32[31]}}, r32};
        end
        pa = (op == MDU_MULH || op == MDU_MULHSU) ? {{64{a[63]}}, a} : {64'd0, a};
        pb = (op == MDU_MULH) ? {{64{b[63]}}, b} : {64'd0, b};
        p  = pa * pb;
        case (op)
            MDU_MUL:                         return p[63:0];
            MDU_MULH, MDU_MULHSU, MDU_MULHU: return p[127:64];
            default: begin
                if (b == 64'd0) return (op == MDU_DIV || op == MDU_DIVU) ? 64'hFFFF_FFFF_FFFF_FFFF : a;
                if ((op == MDU_DIV || op == MDU_REM) && a == 64'h8000_0000_0000_0000 &&
                    b == 64'hFFFF_FFFF_FFFF_FFFF)
                    return (op == MDU_DIV) ? a : 64'd0;
                q64 = sa / sb;
                m64 = sa % sb;
                case (op)
                    MDU_DIV:  return q64;
                    MDU_DIVU: return a / b;
                    MDU_REM:  return m64;
                    default:  return a % b;
                endcase
            end
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] op, input logic w,
                                       input logic [63:0] a, input logic [63:0] b);
        logic zero, ovf;
        zero = w ? (b[31:0] == 32'd0) : (b == 64'd0);
        ovf  = w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                 : (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF);
        if (op[2] && (zero || ((op == MDU_DIV || op == MDU_REM) && ovf))) return 1;
        return LONG_LAT;
    endfunction

    function automatic logic [63:0] rnd_operand();
        case ($urandom_range(0, 6))
            0:       return 64'd0;
            1:       return 64'hFFFF_FFFF_FFFF_FFFF;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'($urandom_range(0, 20));
            4:       return {32'($urandom), 32'h8000_0000};
            5:       return -64'($urandom_range(1, 20));
            default: return {32'($urandom), 32'($urandom)};
        endcase
    endfunction

    task automatic run_op(input logic [2:0] op, input logic w, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] exp, input int lat,
                          input int hold, input string tag);
        int          cyc;
        logic [63:0] first;
        @(negedge clk);
        check_result({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        mdu_op = op; is_word = w; operator_1 = a; operator_2 = b; in_valid = 1'b1;
        @(posedge clk); #1;
        // Scramble the request bus so any late sampling of operands shows up.
        in_valid = 1'b0; operator_1 = {32'($urandom), 32'($urandom)};
        operator_2 = {32'($urandom), 32'($urandom)}; mdu_op = 3'($urandom); is_word = 1'($urandom);
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_result({tag, "_latency"}, 64'(cyc), 64'(lat));
        check_result({tag, "_result"}, mdu_result, exp);
        first = mdu_result;
        if (hold > 0) begin
            repeat (hold) begin
                @(posedge clk); #1;
            end
            check_result({tag, "_hold_result"}, mdu_result, first);
            check_result({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
            check_result({tag, "_hold_in_ready"}, 64'(in_ready), 64'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_result({tag, "_handoff_valid"}, 64'(out_valid), 64'd0);
        check_result({tag, "_handoff_in_ready"}, 64'(in_ready), 64'd1);
    endtask

    task automatic run_ref(input logic [2:0] op, input logic w, input logic [63:0] a,
                           input logic [63:0] b, input int hold, input string tag);
        run_op(op, w, a, b, ref_model(op, w, a, b), ref_latency(op, w, a, b), hold, tag);
    endtask

    initial begin
        logic [2:0] op;
        logic       w;
        logic       saw;
        rst = 1'b1; in_valid = 1'b0; mdu_op = '0; is_word = 1'b0;
        operator_1 = '0; operator_2 = '0; flush = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_result("reset_in_ready", 64'(in_ready), 64'd1);
        check_result("reset_out_valid", 64'(out_valid), 64'd0);
        check_result("reset_result", mdu_result, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases with hand-derived expectations.
        run_op(MDU_MUL,    1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, LONG_LAT, 0, "mul_m1x2");
        run_op(MDU_MULH,   1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, LONG_LAT, 0, "mulh_m1xm1");
        run_op(MDU_MULHU,  1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, LONG_LAT, 0, "mulhu_max");
        run_op(MDU_MULHSU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, LONG_LAT, 0, "mulhsu_m1x2");
        run_op(MDU_DIV,    1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, LONG_LAT, 0, "div_m7_2");
        run_op(MDU_REM,    1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, LONG_LAT, 0, "rem_m7_2");
        run_op(MDU_DIVU,   1'b0, 64'd100, 64'd7, 64'd14, LONG_LAT, 10, "divu_100_7");
        run_op(MDU_REMU,   1'b0, 64'd100, 64'd7, 64'd2, LONG_LAT, 0, "remu_100_7");
        run_op(MDU_DIV,    1'b0, 64'd1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, "div_by0");
        run_op(MDU_REM,    1'b0, 64'd1234, 64'd0, 64'd1234, 1, 2, "rem_by0");
        run_op(MDU_DIV,    1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1, 0, "div_ovf");
        run_op(MDU_REM,    1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1, 0, "rem_ovf");
        run_op(MDU_DIV,    1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1, 0, "divw_ovf");
        run_op(MDU_MUL,    1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, LONG_LAT, 0, "mulw_7fff");

        // Randomized operations against the reference.
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            w  = (op == MDU_MULH || op == MDU_MULHSU || op == MDU_MULHU) ? 1'b0 : 1'($urandom);
            run_ref(op, w, rnd_operand(), rnd_operand(), $urandom_range(0, 3), $sformatf("rnd%0d", i));
        end

        // Flush at counter 30: back to IDLE next cycle, no result ever.
        @(negedge clk);
        mdu_op = MDU_DIV; is_word = 1'b0; operator_1 = 64'd999; operator_2 = 64'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (30) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check_result("flush_in_ready", 64'(in_ready), 64'd1);
        check_result("flush_out_valid", 64'(out_valid), 64'd0);
        saw = 1'b0;
        repeat (80) begin
            @(posedge clk); #1;
            if (out_valid) saw = 1'b1;
        end
        check_result("flush_no_result", 64'(saw), 64'd0);

        // Flush in IDLE blocks an accept (a div-by-zero would otherwise complete in 1 cycle).
        @(negedge clk);
        mdu_op = MDU_DIVU; operator_1 = 64'd5; operator_2 = 64'd0; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_result("idle_flush_in_ready", 64'(in_ready), 64'd1);
        check_result("idle_flush_out_valid", 64'(out_valid), 64'd0);

        // A normal op after the flushes still works.
        run_ref(MDU_DIVU, 1'b0, 64'd1000, 64'd9, 0, "post_flush");

        // Reset in the middle of a divide.
        @(negedge clk);
        mdu_op = MDU_DIV; operator_1 = 64'd77; operator_2 = 64'd5; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_result("midrst_in_ready", 64'(in_ready), 64'd1);
        check_result("midrst_out_valid", 64'(out_valid), 64'd0);
        check_result("midrst_result", mdu_result, 64'd0);
        saw = 1'b0;
        repeat (70) begin
            @(posedge clk); #1;
            if (out_valid) saw = 1'b1;
        end
        check_result("midrst_no_result", 64'(saw), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
